// File: rtl/segment_reader.sv
// segment_reader: debounces the multiplexed seven-segment bus and reassembles the
// displayed hex word, offering each complete frame on a valid/ready output.
module segment_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [8:0]          seg_in,
  input  logic [DIGITS-1:0]   dig_sel,
  output logic [4*DIGITS-1:0] value,
  output logic [DIGITS-1:0]   dp,
  output logic [DIGITS-1:0]   err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);
  localparam logic [7:0]   RUN_MAX = 8'(STABLE_CYCLES);
  localparam logic [111:0] GLYPHS  = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [DIGITS+8:0]   sample, prev_q, prev_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                captured_q, captured_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] sh_val_q, sh_val_d, value_q, value_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, sh_err_q, sh_err_d;
  logic [DIGITS-1:0]   dp_q, dp_d, err_q, err_d;
  logic                out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic                one_hot, same, fire, complete, load, bad;
  logic [3:0]          nib;
  assign sample = {dig_sel, seg_in};
  always_comb begin
    nib = 4'd0;
    bad = 1'b1;
    for (int i = 0; i < 16; i++)
      if (seg_in[6:0] == GLYPHS[7*i +: 7]) begin
        nib = 4'(i);
        bad = 1'b0;
      end
  end
  always_comb begin
    one_hot     = (dig_sel != '0) && ((dig_sel & (dig_sel - DIGITS'(1))) == '0);
    same        = sample == prev_q;
    cnt_d       = !one_hot ? 8'd0 : !same ? 8'd1 : (cnt_q == RUN_MAX) ? cnt_q : cnt_q + 8'd1;
    fire        = one_hot && !captured_q && cnt_d == RUN_MAX;
    // the flag survives only while the same legal sample keeps repeating
    captured_d  = one_hot && same && (captured_q || fire);
    complete    = &seen_q;
    load        = complete && (!out_valid_q || out_ready);
    overrun_d   = complete && !load;
    out_valid_d = load || (out_valid_q && !out_ready);
    value_d     = load ? sh_val_q : value_q;
    dp_d        = load ? sh_dp_q : dp_q;
    err_d       = load ? sh_err_q : err_q;
    seen_d      = (complete ? '0 : seen_q) | (fire ? dig_sel : '0);
    prev_d      = sample;
    sh_val_d    = sh_val_q;
    sh_dp_d     = sh_dp_q;
    sh_err_d    = sh_err_q;
    for (int d = 0; d < DIGITS; d++)
      if (fire && dig_sel[d]) begin
        sh_val_d[4*d +: 4] = nib;
        sh_dp_d[d]         = seg_in[8];
        sh_err_d[d]        = bad;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_q      <= '0;
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      seen_q      <= '0;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_err_q    <= '0;
      value_q     <= '0;
      dp_q        <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      seen_q      <= seen_d;
      sh_val_q    <= sh_val_d;
      sh_dp_q     <= sh_dp_d;
      sh_err_q    <= sh_err_d;
      value_q     <= value_d;
      dp_q        <= dp_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  assign value     = value_q;
  assign dp        = dp_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_segment_reader.sv
// tb_segment_reader: directed and random scans of the display bus, checked every cycle
// against a frame-level reference model.
module tb_segment_reader;
  localparam int D = 4, S = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic clk = 0, rst_n = 1;
  logic [8:0] seg_in = '0;
  logic [D-1:0] dig_sel = '0;
  logic out_ready = 0;
  logic [4*D-1:0] value;
  logic [D-1:0] dp, err;
  logic out_valid, overrun;
  segment_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel), .value(value), .dp(dp),
    .err(err), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  int edge_no = 0, e0 = 0, vcount = 0, v_edge = 0, ocount = 0, o_edge = 0;
  logic [4*D-1:0] last_value;
  logic [D-1:0] last_dp, last_err;
  logic [3:0] sh_nib [D], o_nib [D];
  bit sh_dp [D], sh_err [D], o_dp [D], o_err [D], seen [D];
  bit m_valid, m_ovr;
  logic [D+8:0] m_last;
  int m_len;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int decode(input logic [8:0] p);
    for (int i = 0; i < 16; i++) if (p[6:0] == GLYPH[i]) return i;
    return -1;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      sh_nib[i] = 0; o_nib[i] = 0; sh_dp[i] = 0; sh_err[i] = 0;
      o_dp[i] = 0; o_err[i] = 0; seen[i] = 0;
    end
    m_valid = 0; m_ovr = 0; m_last = '0; m_len = 0;
  endtask
  task automatic model_edge();
    bit complete;
    int g;
    complete = 1;
    for (int i = 0; i < D; i++) complete &= seen[i];
    m_ovr = complete && m_valid && !out_ready;
    if (complete && !m_ovr) begin
      for (int i = 0; i < D; i++) begin o_nib[i] = sh_nib[i]; o_dp[i] = sh_dp[i]; o_err[i] = sh_err[i]; end
      m_valid = 1;
    end else if (m_valid && out_ready) m_valid = 0;
    if (complete) for (int i = 0; i < D; i++) seen[i] = 0;
    m_len = ({dig_sel, seg_in} == m_last) ? m_len + 1 : 1;
    if ($countones(dig_sel) != 1) m_len = 0;
    m_last = {dig_sel, seg_in};
    if (m_len == S)
      for (int i = 0; i < D; i++)
        if (dig_sel[i]) begin
          g = decode(seg_in);
          sh_nib[i] = (g < 0) ? 4'd0 : 4'(g);
          sh_dp[i] = seg_in[8];
          sh_err[i] = g < 0;
          seen[i] = 1;
        end
  endtask
  function automatic logic [63:0] model_out();
    logic [4*D-1:0] v;
    logic [D-1:0] p, e;
    for (int i = 0; i < D; i++) begin v[4*i +: 4] = o_nib[i]; p[i] = o_dp[i]; e[i] = o_err[i]; end
    return 64'({v, p, e, m_valid, m_ovr});
  endfunction
  task automatic cyc(input logic [D-1:0] s, input logic [8:0] g, input logic r);
    dig_sel = s; seg_in = g; out_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    edge_no++;
    chk("outputs", 64'({value, dp, err, out_valid, overrun}), model_out());
    if (out_valid) begin vcount++; v_edge = edge_no; last_value = value; last_dp = dp; last_err = err; end
    if (overrun) begin ocount++; o_edge = edge_no; end
  endtask
  task automatic hold(input int d, input logic [8:0] g, input int n, input logic r);
    repeat (n) cyc(D'(1) << d, g, r);
  endtask
  task automatic frame(input logic [8:0] g0, g1, g2, g3, input logic r);
    hold(0, g0, 6, r); hold(1, g1, 6, r); hold(2, g2, 6, r);
    e0 = edge_no + 1;
    hold(3, g3, 6, r);
  endtask
  initial begin
    model_reset();
    #2 rst_n = 0;
    #1 chk("reset_async", 64'({value, dp, err, out_valid, overrun}), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held", 64'({value, dp, err, out_valid, overrun}), 64'd0);
    rst_n = 1;
    vcount = 0;
    frame(9'h03F, 9'h006, 9'h05B, 9'h04F, 1);
    chk("basic_vcount", 64'(vcount), 64'd1);
    chk("basic_latency", 64'(v_edge - e0 + 1), 64'd5);
    chk("basic_value", 64'(last_value), 64'h3210);
    chk("basic_err", 64'(last_err), 64'd0);
    vcount = 0;
    hold(0, 9'h03F, 6, 1); hold(1, 9'h07F, 3, 1); hold(1, 9'h006, 4, 1);
    hold(2, 9'h05B, 6, 1); hold(3, 9'h04F, 6, 1);
    chk("debounce_a_vcount", 64'(vcount), 64'd1);
    chk("debounce_a_nib1", 64'(last_value[7:4]), 64'd1);
    vcount = 0;
    hold(0, 9'h03F, 6, 1); hold(1, 9'h006, 4, 1); hold(1, 9'h07F, 3, 1);
    hold(2, 9'h05B, 6, 1); hold(3, 9'h04F, 6, 1);
    chk("debounce_b_nib1", 64'(last_value[7:4]), 64'd1);
    frame(9'h03F, 9'h006, 9'h1FF, 9'h0FF, 1);
    chk("glyph_value", 64'(last_value), 64'h8810);
    chk("glyph_dp", 64'(last_dp), 64'b0100);
    chk("glyph_err", 64'(last_err), 64'd0);
    frame(9'h001, 9'h066, 9'h05B, 9'h04F, 1);
    chk("bad_value", 64'(last_value), 64'h3240);
    chk("bad_err", 64'(last_err), 64'b0001);
    ocount = 0;
    frame(9'h006, 9'h05B, 9'h04F, 9'h066, 0);
    frame(9'h07D, 9'h007, 9'h07F, 9'h06F, 0);
    chk("bp_held_value", 64'(value), 64'h4321);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_overrun_count", 64'(ocount), 64'd1);
    chk("bp_overrun_edge", 64'(o_edge - e0 + 1), 64'd5);
    cyc(4'b1000, 9'h06F, 1);
    chk("bp_transfer", 64'(out_valid), 64'd0);
    vcount = 0;
    hold(0, 9'h006, 6, 1); hold(1, 9'h05B, 6, 1);
    repeat (10) cyc(4'b0011, 9'h07D, 1);
    repeat (10) cyc(4'b0000, 9'h066, 1);
    hold(2, 9'h04F, 6, 1);
    e0 = edge_no + 1;
    hold(3, 9'h07F, 6, 1);
    chk("illegal_vcount", 64'(vcount), 64'd1);
    chk("illegal_latency", 64'(v_edge - e0 + 1), 64'd5);
    chk("illegal_value", 64'(last_value), 64'h8321);
    frame(9'h006, 9'h05B, 9'h04F, 9'h066, 0);
    hold(0, 9'h03F, 6, 0); hold(1, 9'h006, 6, 0); hold(2, 9'h05B, 6, 0);
    rst_n = 0;
    #1 chk("reset_mid", 64'({value, dp, err, out_valid, overrun}), 64'd0);
    model_reset();
    @(posedge clk); #1;
    chk("reset_mid_held", 64'({value, dp, err, out_valid, overrun}), 64'd0);
    rst_n = 1;
    vcount = 0;
    frame(9'h07D, 9'h007, 9'h07F, 9'h06F, 1);
    chk("post_reset_vcount", 64'(vcount), 64'd1);
    chk("post_reset_value", 64'(last_value), 64'h9876);
    for (int n = 0; n < 80; n++) begin
      logic [D-1:0] s;
      logic [8:0] g;
      int h, k;
      k = $urandom_range(0, 9);
      s = (k == 0) ? '0 : (k == 1) ? D'($urandom) : D'(1) << $urandom_range(0, D - 1);
      g = ($urandom_range(0, 3) == 0) ? 9'($urandom) : {1'($urandom), 1'($urandom), GLYPH[$urandom_range(0, 15)]};
      h = $urandom_range(1, 8);
      repeat (h) cyc(s, g, 1'($urandom_range(0, 3) != 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/segment_reader.md
# segment_reader

Read-back block for the seven-segment display path. It samples the multiplexed display bus: a one-hot digit select plus the 9-bit segment pattern for the selected digit. It waits until each digit's pattern has been stable for a set number of cycles, then maps the pattern back to a hex nibble. Once every digit has been captured, it presents the assembled word on a valid/ready output, so the display contents can be checked or forwarded without a camera on the board.

## Interface
- DIGITS, 4: number of multiplexed digits (1–8).
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured (2–255).

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg_in  in  9  segment pattern: bit 8 = dp, bit 7 reserved (ignored), bits 6:0 = segments g..a.
- dig_sel  in  DIGITS  one-hot, active-high digit enable.
- value  out  4*DIGITS  captured nibbles; digit i occupies bits 4i+3:4i.
- dp  out  DIGITS  captured dp bit per digit.
- err  out  DIGITS  per digit: 1 = pattern bits 6:0 not in the glyph table.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.

## Operation
- Glyph table, bits 6:0 to nibble:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F
  - Any other pattern → nibble 0 with err=1.
- The previous sample of {dig_sel, seg_in} is registered every cycle.
- Run counter: increments (saturating at STABLE_CYCLES) while the current sample equals the previous sample and dig_sel is exactly one-hot. It resets to 1 on any change. It is forced to 0 while dig_sel is zero or multi-hot.
- Capture: when the counter reaches STABLE_CYCLES, the selected digit's nibble, dp and err are written to shadow registers and that digit's seen bit is set.
  - A `captured` flag blocks re-capture until the sample changes.
  - A digit captured again before the frame completes overwrites its earlier shadow value.
- Frame complete: all seen bits are 1. At the next edge:
  - Output empty, or out_ready=1 in that cycle: shadow is copied to value/dp/err, out_valid=1, all seen bits cleared.
  - Otherwise (out_valid=1 and out_ready=0): the frame is dropped, seen bits are cleared, overrun pulses for 1 cycle, and the output is unchanged.
- Handshake:
  - value/dp/err are stable while out_valid=1 and out_ready=0.
  - The transfer happens on an edge where out_valid and out_ready are both 1.
  - out_valid falls after the transfer unless a new frame loads in the same edge, in which case it stays 1 with the new data.

## Timing
- Reset values: value=0, dp=0, err=0, out_valid=0, overrun=0. Internally, counter=0, seen=0, captured=0, and the previous sample is 0.
- Capture latency: a run whose first cycle is cycle t is captured at the edge ending cycle t+STABLE_CYCLES−1.
- out_valid rises one edge after the capture that completes the frame, i.e. STABLE_CYCLES+1 edges after the last digit's run begins.
- A run shorter than STABLE_CYCLES is ignored; seen bits are not affected.
- A change on seg_in or dig_sel restarts the count, even if the old value returns on the next cycle.
- Reset asserted mid-frame or mid-handshake: all state clears immediately and out_valid drops asynchronously. Partial frames are lost.
- Loading a frame and a consumer transfer in the same edge counts as a load, not an overrun.

## Test plan
- Basic scan (DIGITS=4, STABLE_CYCLES=4):
  - Stimulus: digits 0..3 each held 6 cycles with patterns 3F, 06, 5B, 4F, dp=0; out_ready=1.
  - Required: value=16'h3210, err=0, and a single out_valid cycle 5 edges after digit 3's run starts.
- Debounce:
  - Stimulus: digit 1 shows 7F for 3 cycles, then 06 for 4 cycles; the other digits are valid.
  - Required: nibble 1 = 1; the 7F run is never captured.
- Bad glyph and dp:
  - Stimulus: digit 2 = 0x1FF (bit 8=1, bits 6:0=7F) and digit 3 = 0x0FF (bits 6:0=7F, only reserved bit 7 differs).
  - Required: both nibbles = 8, dp[2]=1, err=0.
  - Stimulus: digit 0 = 0x01.
  - Required: nibble 0 = 0, err[0]=1.
- Backpressure/overrun:
  - Stimulus: out_ready=0 while two full frames are scanned.
  - Required: the first frame is held unchanged and overrun pulses exactly once at the second frame's load edge.
  - Stimulus: raise out_ready.
  - Required: the transfer occurs and out_valid drops.
- Illegal select:
  - Stimulus: dig_sel=4'b0011 for 10 cycles.
  - Required: no capture and seen bits unchanged.
  - Stimulus: dig_sel=0 for 10 cycles.
  - Required: the same.
- Reset mid-frame:
  - Stimulus: capture 3 digits, pulse rst_n low, then scan all 4 digits.
  - Required: exactly one frame, containing post-reset data only; all outputs are 0 during reset.
